// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one synchronous
// write port, optional same-cycle write bypass and hardwired zero register,
// plus a sequential CLEAR (one entry per cycle) with a sticky dropped-write flag.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic              WR_DROPPED
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_CLEARING = 1'b1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              dropped;
  logic              wr_ok;

  // True when the address names the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Read-port value: stored contents, optionally overridden by a live write,
  // and forced to zero for the hardwired register.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] raddr,
    input logic [DATA_W-1:0] stored,
    input logic              fwd
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (fwd && (INADDRESS == raddr)) v = IN;
    if (is_zero(raddr)) v = '0;
    return v;
  endfunction

  assign BUSY       = (state == ST_CLEARING);
  assign WR_DROPPED = dropped;

  // A write lands only when idle and not aimed at the zero register.
  assign wr_ok = WRITE && !BUSY && !is_zero(INADDRESS);

  // Storage update: reset wipes everything, a clear zeroes one entry per
  // cycle, otherwise an accepted write is stored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (BUSY) begin
      regs[clr_cnt] <= '0;
    end else if (wr_ok) begin
      regs[INADDRESS] <= IN;
    end
  end

  // Clear sequencer and sticky dropped-write flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      dropped <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CLEAR) begin
            state   <= ST_CLEARING;
            clr_cnt <= '0;
          end
        end
        ST_CLEARING: begin
          // Counter wraps to 0 naturally after the last index.
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (&clr_cnt) state <= ST_IDLE;
          if (WRITE && !is_zero(INADDRESS)) dropped <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Combinational read ports; forwarding is suppressed while clearing.
  always_comb begin
    OUT1 = read_port(OUT1ADDRESS, regs[OUT1ADDRESS], (BYPASS != 0) && WRITE && !BUSY);
    OUT2 = read_port(OUT2ADDRESS, regs[OUT2ADDRESS], (BYPASS != 0) && WRITE && !BUSY);
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default build (bypass on), a bypass-off
// build and a 16x16 build with the hardwired zero register.
module tb_reg_file_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Instance A: defaults (8x8, BYPASS=1, ZERO_REG=0)
  logic       a_rst, a_wr, a_clr, a_busy, a_drop;
  logic [7:0] a_in, a_o1, a_o2;
  logic [2:0] a_ia, a_o1a, a_o2a;

  // Instance B: BYPASS=0
  logic       b_rst, b_wr, b_clr, b_busy, b_drop;
  logic [7:0] b_in, b_o1, b_o2;
  logic [2:0] b_ia, b_o1a, b_o2a;

  // Instance C: 16 bit, 16 entries, ZERO_REG=1
  logic        c_rst, c_wr, c_clr, c_busy, c_drop;
  logic [15:0] c_in, c_o1, c_o2;
  logic [3:0]  c_ia, c_o1a, c_o2a;

  reg_file_param u_a (
    .CLK(CLK), .RESET(a_rst), .IN(a_in), .INADDRESS(a_ia), .WRITE(a_wr),
    .OUT1ADDRESS(a_o1a), .OUT2ADDRESS(a_o2a), .OUT1(a_o1), .OUT2(a_o2),
    .CLEAR(a_clr), .BUSY(a_busy), .WR_DROPPED(a_drop)
  );

  reg_file_param #(.BYPASS(0)) u_b (
    .CLK(CLK), .RESET(b_rst), .IN(b_in), .INADDRESS(b_ia), .WRITE(b_wr),
    .OUT1ADDRESS(b_o1a), .OUT2ADDRESS(b_o2a), .OUT1(b_o1), .OUT2(b_o2),
    .CLEAR(b_clr), .BUSY(b_busy), .WR_DROPPED(b_drop)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_c (
    .CLK(CLK), .RESET(c_rst), .IN(c_in), .INADDRESS(c_ia), .WRITE(c_wr),
    .OUT1ADDRESS(c_o1a), .OUT2ADDRESS(c_o2a), .OUT1(c_o1), .OUT2(c_o2),
    .CLEAR(c_clr), .BUSY(c_busy), .WR_DROPPED(c_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_write(input logic [2:0] addr, input logic [7:0] data);
    a_wr = 1'b1; a_ia = addr; a_in = data;
    tick();
    a_wr = 1'b0;
  endtask

  logic [7:0] pre [8];
  int         busy_cnt;

  initial begin
    pre = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    a_rst = 1; a_wr = 0; a_clr = 0; a_in = 0; a_ia = 0; a_o1a = 0; a_o2a = 0;
    b_rst = 1; b_wr = 0; b_clr = 0; b_in = 0; b_ia = 0; b_o1a = 0; b_o2a = 0;
    c_rst = 1; c_wr = 0; c_clr = 0; c_in = 0; c_ia = 0; c_o1a = 0; c_o2a = 0;
    tick();
    a_rst = 0; b_rst = 0; c_rst = 0;

    // Reset state: every entry reads zero, flags low
    for (int i = 0; i < 8; i++) begin
      a_o1a = 3'(i); a_o2a = 3'(7 - i);
      #1;
      check("rst_out1", a_o1, 8'h00);
      check("rst_out2", a_o2, 8'h00);
    end
    check("rst_busy", a_busy, 1'b0);
    check("rst_drop", a_drop, 1'b0);

    // Write/read on both ports simultaneously
    a_write(3'd3, 8'hA5);
    a_write(3'd6, 8'h3C);
    a_o1a = 3'd3; a_o2a = 3'd6;
    #1;
    check("wr_out1_r3", a_o1, 8'hA5);
    check("wr_out2_r6", a_o2, 8'h3C);

    // Bypass on: forwarded before the edge, stored after it
    a_o1a = 3'd2; a_wr = 1; a_ia = 3'd2; a_in = 8'h77;
    #1;
    check("byp_pre_edge", a_o1, 8'h77);
    tick();
    a_wr = 0;
    #1;
    check("byp_post_edge", a_o1, 8'h77);

    // Bypass off: old value until the edge
    b_wr = 1; b_ia = 3'd2; b_in = 8'h12;
    tick();
    b_wr = 0;
    b_o1a = 3'd2; b_wr = 1; b_ia = 3'd2; b_in = 8'h77;
    #1;
    check("nobyp_pre_edge", b_o1, 8'h12);
    tick();
    b_wr = 0;
    #1;
    check("nobyp_post_edge", b_o1, 8'h77);

    // Sequential clear of a preloaded file
    for (int i = 0; i < 8; i++) a_write(3'(i), pre[i]);
    a_clr = 1;
    tick();
    a_clr = 0;
    busy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (a_busy) busy_cnt++;
      if (k == 3) begin
        for (int i = 0; i < 3; i++) begin
          a_o1a = 3'(i);
          #1;
          check("clr3_low", a_o1, 8'h00);
        end
        a_o2a = 3'd3;
        #1;
        check("clr3_r3", a_o2, 8'h44);
      end
      tick();
    end
    check("clr_busy_cycles", busy_cnt, 8);
    check("clr_busy_end", a_busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a_o1a = 3'(i);
      #1;
      check("clr_done_zero", a_o1, 8'h00);
    end
    check("clr_no_drop", a_drop, 1'b0);

    // Write during clear is dropped; a second CLEAR mid-clear is ignored
    a_write(3'd5, 8'h5A);
    a_clr = 1;
    tick();
    a_clr = 0;
    busy_cnt = 0;
    a_o1a = 3'd5;
    for (int k = 0; k < 12; k++) begin
      if (a_busy) busy_cnt++;
      if (k == 2) begin
        a_wr = 1; a_ia = 3'd5; a_in = 8'hFF;
        #1;
        check("clr_no_bypass", a_o1, 8'h5A);
      end
      if (k == 4) a_clr = 1;
      tick();
      a_wr = 0; a_clr = 0;
      if (k == 2) begin
        check("drop_set", a_drop, 1'b1);
        check("drop_r5_kept", a_o1, 8'h5A);
      end
    end
    check("drop_busy_cycles", busy_cnt, 8);
    check("drop_busy_end", a_busy, 1'b0);
    check("drop_sticky", a_drop, 1'b1);
    check("drop_r5_zero", a_o1, 8'h00);

    // Zero register: write to r0 discarded silently
    c_wr = 1; c_ia = 4'd0; c_in = 16'hBEEF; c_o1a = 4'd0;
    #1;
    check("z_r0_pre_edge", c_o1, 16'h0000);
    tick();
    c_wr = 0;
    #1;
    check("z_r0_post", c_o1, 16'h0000);
    check("z_no_drop", c_drop, 1'b0);
    c_wr = 1; c_ia = 4'd15; c_in = 16'hBEEF;
    tick();
    c_wr = 0;
    c_o2a = 4'd15;
    #1;
    check("z_r15", c_o2, 16'hBEEF);

    // Reset in the middle of a clear
    c_clr = 1;
    tick();
    c_clr = 0;
    tick(); tick(); tick();
    check("z_busy_mid", c_busy, 1'b1);
    c_rst = 1;
    tick();
    c_rst = 0;
    #1;
    check("z_rst_busy", c_busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      c_o1a = 4'(i);
      #1;
      check("z_rst_zero", c_o1, 16'h0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
